// File: rtl/vga_write_arbiter.sv
// Merges player and obstacle pixel-write streams into one frame-buffer write port.
// Player writes always win; obstacle writes queue in a FIFO and drain on idle cycles.
// While the player is in collision mode, obstacle pixels inside its rectangle are dropped.
module vga_write_arbiter #(
  parameter int nX            = 10,
  parameter int nY            = 9,
  parameter int COLOR_DEPTH   = 9,
  parameter int FIFO_DEPTH    = 16,
  parameter int LANE_WIDTH    = 80,
  parameter int LANE_START_X  = 120,
  parameter int PLAYER_WIDTH  = 60,
  parameter int PLAYER_HEIGHT = 60,
  parameter int PLAYER_Y_POS  = 360
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [nX-1:0]          p_x,
  input  logic [nY-1:0]          p_y,
  input  logic [COLOR_DEPTH-1:0] p_color,
  input  logic                   p_write,
  input  logic                   p_erasing,
  input  logic                   p_collision_mode,
  input  logic [2:0]             player_lane,
  input  logic [nX-1:0]          o_x,
  input  logic [nY-1:0]          o_y,
  input  logic [COLOR_DEPTH-1:0] o_color,
  input  logic                   o_write,
  output logic                   o_ready,
  output logic [nX-1:0]          VGA_x,
  output logic [nY-1:0]          VGA_y,
  output logic [COLOR_DEPTH-1:0] VGA_color,
  output logic                   VGA_write,
  output logic [15:0]            drop_count,
  output logic                   overflow
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int EW     = nX + nY + COLOR_DEPTH;
  localparam int XW     = nX + 2;
  localparam int YW     = nY + 2;
  localparam int PX_OFF = LANE_START_X + (LANE_WIDTH - PLAYER_WIDTH) / 2;

  // Saturating increment so the drop counter sticks at its maximum.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [nX-1:0]          vga_x_q, vga_x_d;
  logic [nY-1:0]          vga_y_q, vga_y_d;
  logic [COLOR_DEPTH-1:0] vga_color_q, vga_color_d;
  logic                   vga_write_q, vga_write_d;
  logic [15:0]            drop_count_q, drop_count_d;
  logic                   overflow_q, overflow_d;

  logic [XW-1:0] px_lo, px_hi;
  logic          hit, shield, full, empty, push, pop;
  logic [EW-1:0] head;

  // Player rectangle bounds, computed wide enough that no lane value can wrap.
  always_comb begin
    px_lo  = XW'(PX_OFF) + XW'(player_lane) * XW'(LANE_WIDTH);
    px_hi  = px_lo + XW'(PLAYER_WIDTH - 1);
    hit    = ({2'b00, o_x} >= px_lo) && ({2'b00, o_x} <= px_hi) &&
             ({2'b00, o_y} >= YW'(PLAYER_Y_POS)) &&
             ({2'b00, o_y} <= YW'(PLAYER_Y_POS + PLAYER_HEIGHT - 1));
    shield = p_collision_mode && !p_erasing;
  end

  // FIFO control, shield filtering and merged output selection.
  always_comb begin
    full         = (count_q == CW'(FIFO_DEPTH));
    empty        = (count_q == '0);
    pop          = !p_write && !empty;
    push         = o_write && !full && !(shield && hit);
    head         = mem_q[rd_ptr_q];
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    overflow_d   = overflow_q || (o_write && full);
    drop_count_d = (o_write && !full && shield && hit) ? sat_inc16(drop_count_q) : drop_count_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_color_d  = vga_color_q;
    vga_write_d  = 1'b0;
    if (p_write) begin
      vga_x_d     = p_x;
      vga_y_d     = p_y;
      vga_color_d = p_color;
      vga_write_d = 1'b1;
    end else if (pop) begin
      vga_x_d     = head[EW-1 -: nX];
      vga_y_d     = head[COLOR_DEPTH +: nY];
      vga_color_d = head[COLOR_DEPTH-1:0];
      vga_write_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_color_q  <= '0;
      vga_write_q  <= 1'b0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_color_q  <= vga_color_d;
      vga_write_q  <= vga_write_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge Clock) begin
    if (push && !Reset) mem_q[wr_ptr_q] <= {o_x, o_y, o_color};
  end

  assign o_ready    = (count_q != CW'(FIFO_DEPTH));
  assign VGA_x      = vga_x_q;
  assign VGA_y      = vga_y_q;
  assign VGA_color  = vga_color_q;
  assign VGA_write  = vga_write_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: directed scenarios plus random traffic against a queue model.
module tb_vga_write_arbiter;

  localparam int LANE_START_X = 120;
  localparam int LANE_WIDTH   = 80;
  localparam int PLAYER_W     = 60;
  localparam int PLAYER_H     = 60;
  localparam int PLAYER_Y     = 360;
  localparam int DEPTH        = 16;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] p_x = '0;
  logic [8:0] p_y = '0;
  logic [8:0] p_color = '0;
  logic       p_write = 1'b0;
  logic       p_erasing = 1'b0;
  logic       p_collision_mode = 1'b0;
  logic [2:0] player_lane = '0;
  logic [9:0] o_x = '0;
  logic [8:0] o_y = '0;
  logic [8:0] o_color = '0;
  logic       o_write = 1'b0;
  logic       o_ready;
  logic [9:0] VGA_x;
  logic [8:0] VGA_y;
  logic [8:0] VGA_color;
  logic       VGA_write;
  logic [15:0] drop_count;
  logic       overflow;

  vga_write_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .p_x(p_x), .p_y(p_y), .p_color(p_color), .p_write(p_write),
    .p_erasing(p_erasing), .p_collision_mode(p_collision_mode), .player_lane(player_lane),
    .o_x(o_x), .o_y(o_y), .o_color(o_color), .o_write(o_write), .o_ready(o_ready),
    .VGA_x(VGA_x), .VGA_y(VGA_y), .VGA_color(VGA_color), .VGA_write(VGA_write),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #10 Clock = ~Clock;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] c;
  } pix_t;

  pix_t q[$];
  logic [9:0]  exp_x;
  logic [8:0]  exp_y;
  logic [8:0]  exp_c;
  logic        exp_w;
  int          exp_drop;
  logic        exp_ovf;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("vga_write", 32'(VGA_write), 32'(exp_w));
    chk("vga_x", 32'(VGA_x), 32'(exp_x));
    chk("vga_y", 32'(VGA_y), 32'(exp_y));
    chk("vga_color", 32'(VGA_color), 32'(exp_c));
    chk("o_ready", 32'(o_ready), 32'(q.size() != DEPTH));
    chk("drop_count", 32'(drop_count), 32'(exp_drop));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  // Advance one clock: predict from the current inputs, then compare after the edge.
  task automatic step();
    int   sz, left;
    bit   hit, shield;
    pix_t h;
    if (Reset) begin
      q.delete();
      exp_x = '0; exp_y = '0; exp_c = '0; exp_w = 1'b0;
      exp_drop = 0; exp_ovf = 1'b0;
    end else begin
      sz     = q.size();
      left   = LANE_START_X + int'(player_lane) * LANE_WIDTH + (LANE_WIDTH - PLAYER_W) / 2;
      hit    = (int'(o_x) >= left) && (int'(o_x) <= left + PLAYER_W - 1) &&
               (int'(o_y) >= PLAYER_Y) && (int'(o_y) <= PLAYER_Y + PLAYER_H - 1);
      shield = p_collision_mode && !p_erasing;
      if (p_write) begin
        exp_x = p_x; exp_y = p_y; exp_c = p_color; exp_w = 1'b1;
      end else if (sz != 0) begin
        h = q.pop_front();
        exp_x = h.x; exp_y = h.y; exp_c = h.c; exp_w = 1'b1;
      end else begin
        exp_w = 1'b0;
      end
      if (o_write) begin
        if (sz == DEPTH) exp_ovf = 1'b1;
        else if (shield && hit) begin
          if (exp_drop != 65535) exp_drop++;
        end else q.push_back('{x: o_x, y: o_y, c: o_color});
      end
    end
    @(posedge Clock);
    #1;
    check_all();
  endtask

  task automatic obst(input int x, input int y, input int c);
    o_write = 1'b1; o_x = 10'(x); o_y = 9'(y); o_color = 9'(c);
  endtask

  initial begin
    // Power-on reset.
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();

    // Load five obstacle pixels behind a player burst, then reset mid-drain.
    p_write = 1'b1; p_x = 10'd5; p_y = 9'd5; p_color = 9'h0AA;
    for (int i = 0; i < 5; i++) begin
      obst(200 + i, 100, i);
      step();
    end
    o_write = 1'b0; p_write = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("reset_fifo_empty", 32'(q.size()), 32'd0);
    for (int i = 0; i < 4; i++) step();

    // Player pass-through.
    p_write = 1'b1; p_x = 10'd290; p_y = 9'd360; p_color = 9'h1C0;
    step();
    chk("pass_x", 32'(VGA_x), 32'd290);
    chk("pass_color", 32'(VGA_color), 32'h1C0);
    p_write = 1'b0;
    step();

    // Priority: obstacles wait behind a 10-cycle player burst.
    p_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p_x = 10'(400 + i); p_y = 9'd10; p_color = 9'(i);
      if (i < 3) obst(100 + i, 50, 3 + i);
      else o_write = 1'b0;
      step();
    end
    p_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) chk("order_x", 32'(VGA_x), 32'(100 + i));
    end

    // Shield filter in lane 2.
    player_lane = 3'd2; p_collision_mode = 1'b1; p_erasing = 1'b0;
    obst(290, 360, 1); step();
    chk("shield_drop1", 32'(drop_count), 32'd1);
    obst(349, 419, 2); step();
    chk("shield_drop2", 32'(drop_count), 32'd2);
    obst(350, 419, 3); step();
    obst(289, 360, 4); step();
    p_erasing = 1'b1;
    obst(290, 360, 5); step();
    o_write = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("erase_pass_x", 32'(VGA_x), 32'd290);
    p_collision_mode = 1'b0; p_erasing = 1'b0;

    // Fill the FIFO behind a player burst, then overflow it.
    p_write = 1'b1;
    for (int i = 0; i < 17; i++) begin
      obst(500 + i, 20, i);
      step();
    end
    chk("full_overflow", 32'(overflow), 32'd1);
    o_write = 1'b0; p_write = 1'b0;
    for (int i = 0; i < 18; i++) step();

    // Stream 40 pixels back to back so the pointers wrap.
    for (int i = 0; i < 40; i++) begin
      obst(i, i, 40 - i);
      step();
    end
    o_write = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Random traffic, with rare resets.
    for (int i = 0; i < 600; i++) begin
      Reset            = ($urandom_range(0, 149) == 0);
      p_write          = ($urandom_range(0, 9) < 5);
      p_x              = 10'($urandom);
      p_y              = 9'($urandom);
      p_color          = 9'($urandom);
      p_erasing        = ($urandom_range(0, 3) == 0);
      p_collision_mode = ($urandom_range(0, 1) == 1);
      player_lane      = 3'($urandom_range(0, 4));
      o_write          = ($urandom_range(0, 9) < 6);
      o_x              = 10'($urandom_range(100, 500));
      o_y              = 9'($urandom_range(340, 440));
      o_color          = 9'($urandom);
      step();
    end
    Reset = 1'b0; p_write = 1'b0; o_write = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Merges the pixel-write streams of the player drawing engine and the obstacle drawing engine into the single write port of the VGA frame-buffer adapter.
- Player writes cannot be stalled, so they always win and pass through with 1-cycle latency.
- Obstacle writes are buffered in a FIFO and drained in player-idle cycles.
- While the player is in collision mode, obstacle pixels falling inside the player's rectangle are discarded, so the red player stays on top.

Parameters:
- nX, 10, X coordinate width
- nY, 9, Y coordinate width
- COLOR_DEPTH, 9, pixel colour width
- FIFO_DEPTH, 16, obstacle FIFO entries (power of 2, >=2)
- LANE_WIDTH, 80, lane width in pixels
- LANE_START_X, 120, X of lane 0 left edge
- PLAYER_WIDTH, 60, player rectangle width
- PLAYER_HEIGHT, 60, player rectangle height
- PLAYER_Y_POS, 360, player rectangle top Y

Ports:
- Clock  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high reset
- p_x  in  nX  player pixel X
- p_y  in  nY  player pixel Y
- p_color  in  COLOR_DEPTH  player pixel colour
- p_write  in  1  player write strobe
- p_erasing  in  1  player engine is erasing its old position
- p_collision_mode  in  1  player is in red collision mode
- player_lane  in  3  current player lane, 0-4
- o_x  in  nX  obstacle pixel X
- o_y  in  nY  obstacle pixel Y
- o_color  in  COLOR_DEPTH  obstacle pixel colour
- o_write  in  1  obstacle write strobe
- o_ready  out  1  FIFO can accept a write (= !full)
- VGA_x  out  nX  merged pixel X
- VGA_y  out  nY  merged pixel Y
- VGA_color  out  COLOR_DEPTH  merged colour
- VGA_write  out  1  merged write strobe
- drop_count  out  16  obstacle pixels discarded by the shield filter (saturating)
- overflow  out  1  sticky: obstacle write arrived while FIFO full

Behaviour:
- Reset (synchronous, any cycle, including mid-drain):
  - VGA_x/VGA_y/VGA_color = 0, VGA_write = 0.
  - FIFO count, read pointer and write pointer = 0; contents discarded.
  - drop_count = 0, overflow = 0.
  - o_ready = 1 in the first cycle after reset.
- Shield rectangle (combinational):
  - px = LANE_START_X + player_lane*LANE_WIDTH + (LANE_WIDTH-PLAYER_WIDTH)/2.
  - Hit when px <= o_x <= px+PLAYER_WIDTH-1 and PLAYER_Y_POS <= o_y <= PLAYER_Y_POS+PLAYER_HEIGHT-1.
  - Compute at nX+2 bits; no wrap.
- Shield active = p_collision_mode && !p_erasing.
- Ingress, per cycle with o_write=1:
  - count == FIFO_DEPTH (full): pixel discarded, overflow <= 1. Not counted in drop_count.
  - else shield active and hit: pixel discarded, drop_count += 1, holding at 16'hFFFF.
  - else: push {o_x, o_y, o_color} at the write pointer.
- o_ready = (count != FIFO_DEPTH), derived from the registered count.
  - A pop in the same cycle does not free space for that cycle's push: full blocks the push.
- Egress (registered, one output per cycle):
  - p_write=1: next cycle VGA_* = p_x/p_y/p_color with VGA_write=1; no pop.
  - else count != 0: pop the head; next cycle VGA_* = head entry with VGA_write=1.
  - else: VGA_write <= 0; VGA_x/y/color hold their last values.
- Simultaneous push and pop (count not full, not empty): count unchanged, both pointers advance.
- Push into an empty FIFO: the entry may pop no earlier than the following cycle (no same-cycle bypass). Minimum obstacle latency is 2 cycles.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Ordering: obstacle pixels leave in arrival order. Player pixels are never reordered.
- Starvation: a continuous player burst (e.g. 3600-cycle draw) stalls the FIFO. Obstacle writes beyond FIFO_DEPTH are lost and flagged by overflow. The obstacle engine must honour o_ready.
- overflow clears only on Reset.

Test Plan:
- Reset mid-drain: load 5 obstacle pixels, assert Reset for 1 cycle → next cycle VGA_write=0, o_ready=1, drop_count=0, overflow=0; FIFO empty, nothing drained afterwards.
- Player pass-through: p_write=1, p_x=290, p_y=360, p_color=9'h1C0 → one cycle later VGA_x=290, VGA_y=360, VGA_color=9'h1C0, VGA_write=1.
- Priority and ordering:
  - Stimulus: 3 obstacle pixels (x=100,101,102) pushed while p_write=1 for 10 cycles.
  - Response: VGA output shows only player pixels for those 10 cycles, then x=100,101,102 in consecutive cycles, then VGA_write=0.
- Shield filter:
  - Setup: player_lane=2, p_collision_mode=1, p_erasing=0.
  - Obstacle at (290,360) → dropped, drop_count=1.
  - Obstacle at (349,419) → dropped, drop_count=2.
  - Obstacle at (350,419) and (289,360) → both output.
  - Repeat with p_erasing=1 → (290,360) is output.
- Full/overflow:
  - Hold p_write=1 and push 16 obstacle pixels → o_ready=0.
  - 17th o_write → overflow=1; only 16 pixels emerge after p_write drops.
- Wrap-around: stream 40 obstacle pixels with p_write=0, o_write on every cycle → 40 outputs in order, count never exceeds 1, pointers wrap cleanly.
